// File: rtl/game_result_screen.sv
// rtl/game_result_screen.sv - BCD round stopwatch with best-time tracking and 3x5 digit result screen
// Renders time-taken and best-time digits over an external label layer, one registered RGB565 pixel per cycle.
module game_result_screen #(
   parameter int          DIGITS   = 4,
   parameter int          TICK_DIV = 625000,
   parameter int          NUM_X    = 30,
   parameter int          TT_Y     = 34,
   parameter int          BT_Y     = 56,
   parameter logic [15:0] FG       = 16'hFFFF,
   parameter logic [15:0] HILITE   = 16'h07E0,
   parameter logic [15:0] BG       = 16'h8204
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  clear_best,
   input  logic [6:0]            x,
   input  logic [5:0]            y,
   input  logic                  label_px,
   output logic [15:0]           oled_data,
   output logic                  running,
   output logic                  new_best,
   output logic [4*DIGITS-1:0]   time_taken,
   output logic [4*DIGITS-1:0]   best_time,
   output logic                  best_valid
);
   localparam int PW = $clog2(TICK_DIV);
   localparam logic [4*DIGITS-1:0] ALL9 = {DIGITS{4'h9}};

   typedef enum logic [1:0] {IDLE, RUN, SHOW} state_t;

   state_t              r_state;
   logic [PW-1:0]       r_presc;
   logic [4*DIGITS-1:0] r_time;
   logic [4*DIGITS-1:0] r_best;
   logic                r_best_valid;
   logic                r_new_best;
   logic                r_running;
   logic [15:0]         r_oled;

   logic                w_tick;
   logic [4*DIGITS-1:0] w_time_next;
   logic                w_tt_px;
   logic                w_bt_px;

   function automatic logic [4*DIGITS-1:0] bcd_inc(input logic [4*DIGITS-1:0] v);
      logic [4*DIGITS-1:0] r;
      logic                c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (c) begin
            if (v[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Bit 14 is the top-left cell; rows of 3 bits run top to bottom.
   function automatic logic [14:0] glyph(input logic [3:0] d);
      case (d)
         4'd0:    glyph = 15'b111_101_101_101_111;
         4'd1:    glyph = 15'b010_110_010_010_111;
         4'd2:    glyph = 15'b111_001_111_100_111;
         4'd3:    glyph = 15'b111_001_111_001_111;
         4'd4:    glyph = 15'b101_101_111_001_001;
         4'd5:    glyph = 15'b111_100_111_001_111;
         4'd6:    glyph = 15'b111_100_111_101_111;
         4'd7:    glyph = 15'b111_001_001_001_001;
         4'd8:    glyph = 15'b111_101_111_101_111;
         4'd9:    glyph = 15'b111_101_111_001_111;
         default: glyph = 15'b000_000_000_000_000;
      endcase
   endfunction

   function automatic logic digit_px(input logic [6:0] px, input logic [5:0] py, input int top,
                                     input logic [4*DIGITS-1:0] val, input logic dash);
      int          dx;
      int          dy;
      int          di;
      logic [3:0]  d;
      logic [3:0]  bi;
      logic [14:0] g;
      dx = int'(px) - NUM_X;
      dy = int'(py) - top;
      if (px > 7'd95 || dx < 0 || dx >= 4*DIGITS || (dx % 4) == 3 || dy < 0 || dy > 4)
         return 1'b0;
      di = dx / 4;
      d  = 4'(val >> (4*(DIGITS-1-di)));
      g  = dash ? 15'b000_000_111_000_000 : glyph(d);
      bi = 4'(14 - 3*dy - (dx % 4));
      return g[bi];
   endfunction

   assign w_tick      = (r_state == RUN) && (r_presc == PW'(TICK_DIV-1));
   assign w_time_next = (w_tick && r_time != ALL9) ? bcd_inc(r_time) : r_time;
   assign w_tt_px     = digit_px(x, y, TT_Y, r_time, 1'b0);
   assign w_bt_px     = digit_px(x, y, BT_Y, r_best, !r_best_valid);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_presc      <= '0;
         r_time       <= '0;
         r_best       <= '0;
         r_best_valid <= 1'b0;
         r_new_best   <= 1'b0;
         r_running    <= 1'b0;
      end else begin
         if (clear_best) begin
            r_best       <= '0;
            r_best_valid <= 1'b0;
            r_new_best   <= 1'b0;
         end
         case (r_state)
            RUN: begin
               r_presc <= w_tick ? '0 : r_presc + 1'b1;
               r_time  <= w_time_next;
               // A concurrent clear already invalidated best, so the finishing round wins.
               if (stop) begin
                  r_state   <= SHOW;
                  r_running <= 1'b0;
                  if (!r_best_valid || clear_best || w_time_next < r_best) begin
                     r_best       <= w_time_next;
                     r_best_valid <= 1'b1;
                     r_new_best   <= 1'b1;
                  end
               end
            end
            default: begin
               if (start) begin
                  r_state    <= RUN;
                  r_running  <= 1'b1;
                  r_presc    <= '0;
                  r_time     <= '0;
                  r_new_best <= 1'b0;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_oled <= BG;
      else if (w_tt_px)  r_oled <= FG;
      else if (w_bt_px)  r_oled <= r_new_best ? HILITE : FG;
      else if (label_px) r_oled <= FG;
      else               r_oled <= BG;
   end

   assign oled_data  = r_oled;
   assign running    = r_running;
   assign new_best   = r_new_best;
   assign time_taken = r_time;
   assign best_time  = r_best;
   assign best_valid = r_best_valid;
endmodule
